// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter
// Drains N_IN upstream FIFOs into one downstream FIFO. Each cycle it grants
// at most one eligible requester and pops it. One cycle later it pushes the
// returned word downstream.
// After a pop, a requester is masked for HOLDOFF cycles. This covers the
// registered empty-flag lag of the upstream FIFOs.
// Optional build macro ARB_STRICT_PRIO_EN selects fixed priority, where the
// lowest eligible index wins. The default build uses round-robin arbitration
// that starts after the last grant.

// Per-lane eligibility: the cooldown counter plus the non-empty qualifier.
module fifo_pop_lane #(
   parameter int HOLDOFF = 2
) (
   input  logic clk,
   input  logic reset_L,
   input  logic empty,
   input  logic load,
   output logic eligible
);

   logic [1:0] cool;

   // Reload on the edge that issues this lane's pop, then count down to zero
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         cool <= '0;
      else if (load)
         cool <= 2'(HOLDOFF);
      else if (cool != 2'd0)
         cool <= cool - 2'd1;
   end

   assign eligible = ~empty & (cool == 2'd0);

endmodule

module fifo_pop_arbiter #(
   parameter  int N_IN    = 4,
   parameter  int DW      = 6,
   parameter  int HOLDOFF = 2,
   localparam int IW      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic               clk,
   input  logic               reset_L,
   input  logic               enable,
   input  logic [N_IN-1:0]    fifo_empty,
   input  logic [N_IN*DW-1:0] fifo_data_in,
   input  logic               out_pause,
   input  logic               out_full,
   output logic [N_IN-1:0]    pop,
   output logic               push_out,
   output logic [DW-1:0]      data_out,
   output logic [IW-1:0]      grant_idx,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2
   } state_t;

   // Stage 0 marks a pop in flight, and stage STAGES marks the matching push
   localparam int STAGES = 1;

   state_t            st;
   logic [STAGES:0]   vld_pipe;
   logic [N_IN-1:0]   elig;
   logic [N_IN-1:0]   gnt_oh;
   logic              sel_found;
   logic [IW-1:0]     sel_idx;
   logic              bp;
   logic              grant_fire;
   logic [IW-1:0]     push_idx;

   // One cooldown/eligibility lane per upstream FIFO
   for (genvar i = 0; i < N_IN; i++) begin : g_lane
      fifo_pop_lane #(.HOLDOFF(HOLDOFF)) u_lane (
         .clk      (clk),
         .reset_L  (reset_L),
         .empty    (fifo_empty[i]),
         .load     (gnt_oh[i]),
         .eligible (elig[i])
      );
   end

`ifdef ARB_STRICT_PRIO_EN
   // Fixed priority: scan from the top down so that the lowest eligible index wins last
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = N_IN - 1; k >= 0; k--) begin
         if (elig[IW'(k)]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(k);
         end
      end
   end
`else
   int rr_pos;

   // Round-robin: start after the last grant and wrap; the first eligible requester wins
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      rr_pos    = 0;
      for (int k = 0; k < N_IN; k++) begin
         rr_pos = int'(grant_idx) + 1 + k;
         if (rr_pos >= N_IN)
            rr_pos = rr_pos - N_IN;
         if (!sel_found && elig[IW'(rr_pos)]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(rr_pos);
         end
      end
   end
`endif

   assign bp         = out_pause | out_full;
   assign grant_fire = (st == S_RUN) & enable & ~bp & sel_found;

   // One-hot decode of the grant that this edge will issue
   always_comb begin
      gnt_oh = '0;
      if (grant_fire)
         gnt_oh[sel_idx] = 1'b1;
   end

   // Scheduler FSM with registered pop strobes and the last-grant pointer.
   // A low enable overrides backpressure and forces IDLE.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         st        <= S_IDLE;
         pop       <= '0;
         grant_idx <= IW'(N_IN - 1);
      end else begin
         pop <= gnt_oh;
         if (grant_fire)
            grant_idx <= sel_idx;
         case (st)
            S_IDLE:  if (enable) st <= S_RUN;
            S_RUN: begin
               if (!enable)  st <= S_IDLE;
               else if (bp)  st <= S_STALL;
            end
            S_STALL: begin
               if (!enable)  st <= S_IDLE;
               else if (!bp) st <= S_RUN;
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   // Pop-to-push pipeline. It runs independently of the FSM state, so a
   // scheduled push always completes. Only reset drops it.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         vld_pipe <= '0;
         push_idx <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], grant_fire};
         if (vld_pipe[0])
            push_idx <= grant_idx;
      end
   end

   assign push_out = vld_pipe[STAGES];
   assign data_out = push_out ? fifo_data_in[int'(push_idx)*DW +: DW] : '0;
   assign state    = st;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// tb_fifo_pop_arbiter: scenario tasks with a push-data scoreboard.
// Instance A (HOLDOFF=2) is fed by behavioural upstream FIFOs.
// Instance B (HOLDOFF=0) is fed by static flags and data.
module tb_fifo_pop_arbiter;
   localparam int N  = 4;
   localparam int DW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Instance A
   logic            rst_a, en_a, pause_a, full_a;
   logic [N-1:0]    empty_a, pop_a;
   logic [N*DW-1:0] din_a;
   logic            push_a;
   logic [DW-1:0]   dout_a;
   logic [1:0]      gidx_a, st_a;

   fifo_pop_arbiter #(.N_IN(N), .DW(DW), .HOLDOFF(2)) u_dut_a (
      .clk(clk), .reset_L(rst_a), .enable(en_a), .fifo_empty(empty_a),
      .fifo_data_in(din_a), .out_pause(pause_a), .out_full(full_a),
      .pop(pop_a), .push_out(push_a), .data_out(dout_a),
      .grant_idx(gidx_a), .state(st_a));

   // Instance B
   logic            rst_b, en_b, pause_b, full_b;
   logic [N-1:0]    empty_b, pop_b;
   logic [N*DW-1:0] din_b;
   logic            push_b;
   logic [DW-1:0]   dout_b;
   logic [1:0]      gidx_b, st_b;

   fifo_pop_arbiter #(.N_IN(N), .DW(DW), .HOLDOFF(0)) u_dut_b (
      .clk(clk), .reset_L(rst_b), .enable(en_b), .fifo_empty(empty_b),
      .fifo_data_in(din_b), .out_pause(pause_b), .out_full(full_b),
      .pop(pop_b), .push_out(push_b), .data_out(dout_b),
      .grant_idx(gidx_b), .state(st_b));

   // Upstream FIFO model for A: registered read data, registered empty flag
   int            cnt [N];
   int            rd  [N];
   logic [DW-1:0] dq  [N];
   logic          fifo_clr = 1'b1;

   function automatic logic [DW-1:0] word(input int i, input int k);
      return DW'(42 + (i - 1) * 11 + k * 5);
   endfunction

   function automatic int oh2idx(input logic [N-1:0] v);
      int r;
      r = 0;
      for (int j = 0; j < N; j++) if (v[j]) r = j;
      return r;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (fifo_clr) begin
            rd[i] <= 0;
            dq[i] <= '0;
         end else if (pop_a[i] && rd[i] < cnt[i]) begin
            dq[i] <= word(i, rd[i]);
            rd[i] <= rd[i] + 1;
         end
      end
   end

   always_comb begin
      empty_a = '0;
      din_a   = '0;
      for (int i = 0; i < N; i++) begin
         empty_a[i]          = (rd[i] >= cnt[i]);
         din_a[i*DW +: DW]   = dq[i];
      end
   end

   logic [DW-1:0] sb [$];
   int            exp_rd [N];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input int c0, input int c1, input int c2, input int c3);
      rst_a = 1'b0; en_a = 1'b0; pause_a = 1'b0; full_a = 1'b0; fifo_clr = 1'b1;
      cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
      sb.delete();
      for (int i = 0; i < N; i++) exp_rd[i] = 0;
      tick(); tick();
      fifo_clr = 1'b0; rst_a = 1'b1; en_a = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst_a = 1'b0; en_a = 1'b0; pause_a = 1'b0; full_a = 1'b0;
      rst_b = 1'b0; en_b = 1'b0; pause_b = 1'b0; full_b = 1'b0;
      empty_b = '1; din_b = '0;
      #12;
      checks++; if (pop_a !== 4'b0000) begin failures++; $display("FAIL reset_pop: got %b expected 0000", pop_a); end
      checks++; if (push_a !== 1'b0) begin failures++; $display("FAIL reset_push: got %b expected 0", push_a); end
      checks++; if (dout_a !== 6'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", dout_a); end
      checks++; if (st_a !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", st_a); end
      checks++; if (gidx_a !== 2'd3) begin failures++; $display("FAIL reset_gidx: got %0d expected 3", gidx_a); end
      checks++; if (pop_b !== 4'b0000) begin failures++; $display("FAIL reset_pop_b: got %b expected 0000", pop_b); end
      checks++; if (gidx_b !== 2'd3) begin failures++; $display("FAIL reset_gidx_b: got %0d expected 3", gidx_b); end
   endtask

   task automatic test_round_robin;
      logic [N-1:0]  ep [7];
      logic          prev;
      logic [DW-1:0] exp_w;
      logic [1:0]    exp_g;
      int            idx;
`ifdef ARB_STRICT_PRIO_EN
      ep = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001};
      exp_g = 2'd0;
`else
      ep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      exp_g = 2'd2;
`endif
      start_a(4, 4, 4, 4);
      prev = 1'b0;
      for (int s = 0; s < 7; s++) begin
         tick();
         checks++;
         if (pop_a !== ep[s]) begin failures++; $display("FAIL rr_pop step %0d: got %b expected %b", s, pop_a, ep[s]); end
         checks++;
         if (push_a !== prev) begin failures++; $display("FAIL rr_push step %0d: got %b expected %b", s, push_a, prev); end
         if (prev) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL rr_data step %0d: scoreboard empty, got %h", s, dout_a); end
            else begin
               exp_w = sb.pop_front();
               if (dout_a !== exp_w) begin failures++; $display("FAIL rr_data step %0d: got %h expected %h", s, dout_a, exp_w); end
            end
         end
         if (ep[s] != '0) begin
            idx = oh2idx(ep[s]);
            sb.push_back(word(idx, exp_rd[idx]));
            exp_rd[idx]++;
         end
         prev = (ep[s] != '0);
      end
      checks++;
      if (gidx_a !== exp_g) begin failures++; $display("FAIL rr_gidx: got %0d expected %0d", gidx_a, exp_g); end
   endtask

   task automatic test_single_requester;
      logic [N-1:0]  ep [12];
      logic          prev;
      logic [DW-1:0] exp_w;
      int            idx;
      ep = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000,
             4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      start_a(0, 0, 3, 0);
      prev = 1'b0;
      for (int s = 0; s < 12; s++) begin
         tick();
         checks++;
         if (pop_a !== ep[s]) begin failures++; $display("FAIL single_pop step %0d: got %b expected %b", s, pop_a, ep[s]); end
         checks++;
         if (push_a !== prev) begin failures++; $display("FAIL single_push step %0d: got %b expected %b", s, push_a, prev); end
         if (prev) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL single_data step %0d: scoreboard empty, got %h", s, dout_a); end
            else begin
               exp_w = sb.pop_front();
               if (dout_a !== exp_w) begin failures++; $display("FAIL single_data step %0d: got %h expected %h", s, dout_a, exp_w); end
            end
         end
         if (ep[s] != '0) begin
            idx = oh2idx(ep[s]);
            sb.push_back(word(idx, exp_rd[idx]));
            exp_rd[idx]++;
         end
         prev = (ep[s] != '0);
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL single_left: %0d words never pushed, expected 0", sb.size()); end
   endtask

   task automatic test_pause;
      logic [N-1:0]  ep [7];
      logic          prev;
      logic [DW-1:0] exp_w;
      logic [1:0]    exp_st;
      int            idx;
`ifdef ARB_STRICT_PRIO_EN
      ep = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
`else
      ep = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
`endif
      start_a(4, 4, 4, 4);
      prev = 1'b0;
      for (int s = 0; s < 7; s++) begin
         tick();
         checks++;
         if (pop_a !== ep[s]) begin failures++; $display("FAIL pause_pop step %0d: got %b expected %b", s, pop_a, ep[s]); end
         checks++;
         if (push_a !== prev) begin failures++; $display("FAIL pause_push step %0d: got %b expected %b", s, push_a, prev); end
         if (prev) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL pause_data step %0d: scoreboard empty, got %h", s, dout_a); end
            else begin
               exp_w = sb.pop_front();
               if (dout_a !== exp_w) begin failures++; $display("FAIL pause_data step %0d: got %h expected %h", s, dout_a, exp_w); end
            end
         end
         if (s == 2 || s == 3 || s == 6) begin
            exp_st = (s == 3) ? 2'd1 : 2'd2;
            checks++;
            if (st_a !== exp_st) begin failures++; $display("FAIL pause_state step %0d: got %0d expected %0d", s, st_a, exp_st); end
         end
         if (ep[s] != '0) begin
            idx = oh2idx(ep[s]);
            sb.push_back(word(idx, exp_rd[idx]));
            exp_rd[idx]++;
         end
         prev = (ep[s] != '0);
         if (s == 1) pause_a = 1'b1;
         if (s == 2) pause_a = 1'b0;
         if (s == 5) full_a  = 1'b1;
      end
   endtask

   task automatic test_enable_drop;
      logic [N-1:0]  ep [5];
      logic          prev;
      logic [DW-1:0] exp_w;
      int            idx;
      ep = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      start_a(4, 4, 4, 4);
      prev = 1'b0;
      for (int s = 0; s < 5; s++) begin
         tick();
         checks++;
         if (pop_a !== ep[s]) begin failures++; $display("FAIL endrop_pop step %0d: got %b expected %b", s, pop_a, ep[s]); end
         checks++;
         if (push_a !== prev) begin failures++; $display("FAIL endrop_push step %0d: got %b expected %b", s, push_a, prev); end
         if (prev) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL endrop_data step %0d: scoreboard empty, got %h", s, dout_a); end
            else begin
               exp_w = sb.pop_front();
               if (dout_a !== exp_w) begin failures++; $display("FAIL endrop_data step %0d: got %h expected %h", s, dout_a, exp_w); end
            end
         end
         if (s == 1) begin
            checks++;
            if (st_a !== 2'd0) begin failures++; $display("FAIL endrop_state: got %0d expected 0", st_a); end
         end
         if (ep[s] != '0) begin
            idx = oh2idx(ep[s]);
            sb.push_back(word(idx, exp_rd[idx]));
            exp_rd[idx]++;
         end
         prev = (ep[s] != '0);
         if (s == 0) en_a = 1'b0;
      end
   endtask

   task automatic test_reset_mid_run;
      start_a(4, 4, 4, 4);
      tick(); tick(); tick();
      checks++;
      if (pop_a !== 4'b0100 || push_a !== 1'b1) begin
         failures++; $display("FAIL midrst_pre: got pop=%b push=%b expected pop=0100 push=1", pop_a, push_a);
      end
      #2 rst_a = 1'b0;
      #1;
      checks++; if (pop_a !== 4'b0000) begin failures++; $display("FAIL midrst_pop: got %b expected 0000", pop_a); end
      checks++; if (push_a !== 1'b0) begin failures++; $display("FAIL midrst_push: got %b expected 0", push_a); end
      checks++; if (dout_a !== 6'h00) begin failures++; $display("FAIL midrst_data: got %h expected 00", dout_a); end
      checks++; if (st_a !== 2'd0) begin failures++; $display("FAIL midrst_state: got %0d expected 0", st_a); end
      checks++; if (gidx_a !== 2'd3) begin failures++; $display("FAIL midrst_gidx: got %0d expected 3", gidx_a); end
      tick();
      checks++;
      if (pop_a !== 4'b0000 || push_a !== 1'b0) begin
         failures++; $display("FAIL midrst_hold: got pop=%b push=%b expected pop=0000 push=0", pop_a, push_a);
      end
   endtask

   task automatic test_holdoff0;
      logic [N-1:0]  ep [4];
      logic          prev;
      logic [DW-1:0] exp_w;
      int            pidx;
`ifdef ARB_STRICT_PRIO_EN
      ep = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
      ep = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
      empty_b = 4'b0110;
      din_b   = {6'h33, 6'h22, 6'h11, 6'h05};
      tick();
      rst_b = 1'b1; en_b = 1'b1;
      tick();
      prev = 1'b0;
      pidx = 0;
      for (int s = 0; s < 4; s++) begin
         tick();
         checks++;
         if (pop_b !== ep[s]) begin failures++; $display("FAIL h0_pop step %0d: got %b expected %b", s, pop_b, ep[s]); end
         checks++;
         if (push_b !== prev) begin failures++; $display("FAIL h0_push step %0d: got %b expected %b", s, push_b, prev); end
         if (prev) begin
            exp_w = din_b[pidx*DW +: DW];
            checks++;
            if (dout_b !== exp_w) begin failures++; $display("FAIL h0_data step %0d: got %h expected %h", s, dout_b, exp_w); end
         end
         pidx = oh2idx(ep[s]);
         prev = (ep[s] != '0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single_requester();
      test_pause();
      test_enable_drop();
      test_reset_mid_run();
      test_holdoff0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Round-robin pop scheduler that drains N_IN upstream 6-bit FIFOs into a single downstream FIFO. Each cycle it grants at most one non-empty upstream FIFO, issues its pop, and one cycle later pushes the returned word downstream. It honours the downstream Pausa/Fifo_Full backpressure and masks each requester for HOLDOFF cycles after a pop, which covers the registered empty-flag lag of the upstream FIFOs. Sits between the per-lane FIFOs and the shared output FIFO.

## Interface
- N_IN, 4, number of upstream FIFOs (2..8)
- DW, 6, data width
- HOLDOFF, 2, cycles a requester stays ineligible after being popped (0..3)
- clk  in  1  single clock, all logic on posedge
- reset_L  in  1  asynchronous, active-low reset
- enable  in  1  scheduler run enable
- fifo_empty  in  N_IN  upstream Fifo_Empty flags, bit i = FIFO i
- fifo_data_in  in  N_IN*DW  upstream Fifo_Data_out buses, FIFO i at bits [i*DW +: DW]
- out_pause  in  1  downstream Pausa (almost full)
- out_full  in  1  downstream Fifo_Full
- pop  out  N_IN  registered one-hot pop strobes to upstream FIFOs
- push_out  out  1  registered push strobe to downstream FIFO
- data_out  out  DW  word to downstream Fifo_Data_in
- grant_idx  out  clog2(N_IN)  index of the most recent grant
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 STALL

## Operation
- Eligibility of requester i: fifo_empty[i]=0 and cool[i]=0. cool[i] loads HOLDOFF on the edge that asserts pop[i], decrements to 0 otherwise.
- Round-robin: search starts at (grant_idx+1) mod N_IN, wraps; first eligible wins. grant_idx updates only on a grant.
- FSM:
  - IDLE: no pops. To RUN when enable=1.
  - RUN: grant when any requester is eligible and out_pause=0 and out_full=0. To STALL when out_pause or out_full=1 (no grant that cycle). To IDLE when enable=0.
  - STALL: no pops. To RUN when out_pause=0, out_full=0 and enable=1. To IDLE when enable=0.
- In-flight words: a push already scheduled always completes regardless of state change, pause or enable drop.
- Simultaneous enable=0 and pause: enable wins (IDLE).
- data_out = fifo_data_in slice of the delayed grant index when push_out=1, else 0.
- Reset (async, any time, including mid-transfer): pop=0, push_out=0, data_out=0, grant_idx=N_IN-1 (first search starts at 0), all cool[i]=0, state=IDLE. An in-flight word is dropped.

## Timing
- Decision at edge E from inputs sampled before E; pop[i] high for exactly one cycle after E.
- Upstream memory registers its read on that pop edge; push_out high in the following cycle (pop-to-push latency 1 cycle), data_out combinational from fifo_data_in during that cycle.
- Maximum throughput one word per cycle (needs ≥ HOLDOFF+1 eligible requesters); a single requester is popped at most once every HOLDOFF+1 cycles.
- Backpressure latency: out_pause seen before E → no pop after E; at most one push follows its assertion. Downstream almost-full threshold must leave ≥2 free slots.

## Configuration
- ARB_STRICT_PRIO_EN defined: fixed priority, lowest eligible index wins; grant_idx still reported, not used for search.
- Not defined (default): round-robin as described above.

## Test plan
- Reset mid-run: reset_L low while pop=0100, push_out=1 -> pop=0000, push_out=0, data_out=0, state=0 immediately, without a clock edge.
- All four non-empty, enable=1, HOLDOFF=2 -> pop sequence 0001,0010,0100,1000,0001; push_out one cycle after each pop with data_out = that FIFO's word (e.g. 6'h2A from FIFO 1).
- Only FIFO 2 non-empty holding 3 words -> pop 0100,0000,0000,0100,0000,0000,0100; three pushes; no pop after fifo_empty[2] rises.
- out_pause rises in RUN after pop=0010 -> next cycle pop=0000, push_out=1 for FIFO 1's word, state=2; pause falls -> RUN, next grant is FIFO 2.
- enable drops with a pop issued -> state=0, pending push completes, no further pops.
- HOLDOFF=0, FIFOs 0 and 3 non-empty -> default: 0001,1000,0001,1000; with ARB_STRICT_PRIO_EN: 0001,0001,0001.
